// File: rtl/qos_wrr_arbiter.sv
// rtl/qos_wrr_arbiter.sv - five-class weighted round-robin arbiter feeding one output FIFO
//
// Purpose: picks at most one of five class FIFOs per cycle using per-class
// credits, drives that FIFO's pop strobe, and forwards the popped word to the
// output FIFO one cycle later. Stalls while the output FIFO is almost full.
//
// Ports:
//   clk, reset_L                 clock (rising edge), asynchronous active-low reset
//   fifoN_empty / fifoN_data     class FIFO N status and read data (N = 0..4)
//   out_almost_full              output FIFO back-pressure
//   fifoN_pop                    pop strobe to class FIFO N (combinational, one-hot or zero)
//   push / data_out / grant_idx  registered write to the output FIFO and source index
//   IDLE                         registered flag, high while the arbiter is idle

module qos_wrr_arbiter #(
    parameter int         DW = 10,
    parameter logic [3:0] W0 = 4'd4,
    parameter logic [3:0] W1 = 4'd3,
    parameter logic [3:0] W2 = 4'd2,
    parameter logic [3:0] W3 = 4'd1,
    parameter logic [3:0] W4 = 4'd1
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          fifo0_empty,
    input  logic          fifo1_empty,
    input  logic          fifo2_empty,
    input  logic          fifo3_empty,
    input  logic          fifo4_empty,
    input  logic [DW-1:0] fifo0_data,
    input  logic [DW-1:0] fifo1_data,
    input  logic [DW-1:0] fifo2_data,
    input  logic [DW-1:0] fifo3_data,
    input  logic [DW-1:0] fifo4_data,
    input  logic          out_almost_full,
    output logic          fifo0_pop,
    output logic          fifo1_pop,
    output logic          fifo2_pop,
    output logic          fifo3_pop,
    output logic          fifo4_pop,
    output logic          push,
    output logic [DW-1:0] data_out,
    output logic          IDLE,
    output logic [2:0]    grant_idx
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_ptr;
    logic [2:0]    w_ptr_nxt;
    logic [3:0]    r_credit;
    logic [3:0]    w_credit_nxt;
    logic          r_push;
    logic [DW-1:0] r_data;
    logic [2:0]    r_grant;
    logic          r_idle;

    logic [4:0]    w_nonempty;
    logic [7:0]    w_nonempty8;
    logic          w_found;
    logic [2:0]    w_srch_idx;
    logic          w_pop_any;
    logic [2:0]    w_pop_idx;
    logic [4:0]    w_pop_vec;
    logic [DW-1:0] w_sel_data;

    // A programmed weight of zero still grants one pop per turn.
    function automatic logic [3:0] eff_weight(input logic [2:0] idx);
        logic [3:0] w;
        case (idx)
            3'd0:    w = W0;
            3'd1:    w = W1;
            3'd2:    w = W2;
            3'd3:    w = W3;
            default: w = W4;
        endcase
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    // (p + s) mod 5 for p in 0..4, s in 1..5.
    function automatic logic [2:0] wrap_add(input logic [2:0] p, input logic [2:0] s);
        logic [3:0] t;
        t = {1'b0, p} + {1'b0, s};
        if (t >= 4'd5) begin
            t = t - 4'd5;
        end
        return t[2:0];
    endfunction

    assign w_nonempty  = ~{fifo4_empty, fifo3_empty, fifo2_empty, fifo1_empty, fifo0_empty};
    assign w_nonempty8 = {3'b000, w_nonempty};

    // Circular search starting after ptr; the fifth candidate is ptr itself so a
    // lone busy FIFO is re-selected with a fresh credit. Walking the offsets from
    // far to near lets the nearest hit win without an early exit.
    always_comb begin
        w_found    = 1'b0;
        w_srch_idx = 3'd0;
        for (int s = 5; s >= 1; s--) begin
            if (w_nonempty8[wrap_add(r_ptr, 3'(s))]) begin
                w_found    = 1'b1;
                w_srch_idx = wrap_add(r_ptr, 3'(s));
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        w_pop_any    = 1'b0;
        w_pop_idx    = 3'd0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt  = ST_IDLE;
                w_ptr_nxt    = 3'd0;
                w_credit_nxt = eff_weight(3'd0);
            end
            ST_IDLE: begin
                if (|w_nonempty) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!out_almost_full) begin
                    if (w_nonempty8[r_ptr] && (r_credit != 4'd0)) begin
                        w_pop_any    = 1'b1;
                        w_pop_idx    = r_ptr;
                        w_credit_nxt = r_credit - 4'd1;
                    end else if (w_found) begin
                        w_pop_any    = 1'b1;
                        w_pop_idx    = w_srch_idx;
                        w_ptr_nxt    = w_srch_idx;
                        w_credit_nxt = eff_weight(w_srch_idx) - 4'd1;
                    end
                end
                if (!w_pop_any && !(|w_nonempty)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign w_pop_vec = w_pop_any ? (5'b00001 << w_pop_idx) : 5'b00000;
    assign fifo0_pop = w_pop_vec[0];
    assign fifo1_pop = w_pop_vec[1];
    assign fifo2_pop = w_pop_vec[2];
    assign fifo3_pop = w_pop_vec[3];
    assign fifo4_pop = w_pop_vec[4];

    always_comb begin
        w_sel_data = fifo0_data;
        case (w_pop_idx)
            3'd0:    w_sel_data = fifo0_data;
            3'd1:    w_sel_data = fifo1_data;
            3'd2:    w_sel_data = fifo2_data;
            3'd3:    w_sel_data = fifo3_data;
            default: w_sel_data = fifo4_data;
        endcase
    end

    // The selected FIFO's read data is captured on the edge that retires its pop,
    // so the word reaches the output FIFO together with push one cycle later.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= ST_INIT;
            r_ptr    <= 3'd0;
            r_credit <= 4'd0;
            r_push   <= 1'b0;
            r_data   <= '0;
            r_grant  <= 3'd0;
            r_idle   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
            r_push   <= w_pop_any;
            r_idle   <= (w_state_nxt == ST_IDLE);
            if (w_pop_any) begin
                r_data  <= w_sel_data;
                r_grant <= w_pop_idx;
            end
        end
    end

    assign push      = r_push;
    assign data_out  = r_data;
    assign grant_idx = r_grant;
    assign IDLE      = r_idle;

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// tb/tb_qos_wrr_arbiter.sv - self-checking bench for qos_wrr_arbiter

module tb_qos_wrr_arbiter;

    localparam int         DW  = 10;
    localparam logic [3:0] TW0 = 4'd4;
    localparam logic [3:0] TW1 = 4'd3;
    localparam logic [3:0] TW2 = 4'd2;
    localparam logic [3:0] TW3 = 4'd0;
    localparam logic [3:0] TW4 = 4'd1;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [4:0]    emp;
    logic [DW-1:0] din [5];
    logic          af;
    logic [4:0]    pop;
    logic          push;
    logic [DW-1:0] dout;
    logic          idle;
    logic [2:0]    gidx;

    always #5 clk = ~clk;

    qos_wrr_arbiter #(
        .DW(DW), .W0(TW0), .W1(TW1), .W2(TW2), .W3(TW3), .W4(TW4)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .fifo0_empty    (emp[0]),
        .fifo1_empty    (emp[1]),
        .fifo2_empty    (emp[2]),
        .fifo3_empty    (emp[3]),
        .fifo4_empty    (emp[4]),
        .fifo0_data     (din[0]),
        .fifo1_data     (din[1]),
        .fifo2_data     (din[2]),
        .fifo3_data     (din[3]),
        .fifo4_data     (din[4]),
        .out_almost_full(af),
        .fifo0_pop      (pop[0]),
        .fifo1_pop      (pop[1]),
        .fifo2_pop      (pop[2]),
        .fifo3_pop      (pop[3]),
        .fifo4_pop      (pop[4]),
        .push           (push),
        .data_out       (dout),
        .IDLE           (idle),
        .grant_idx      (gidx)
    );

    // Class FIFO contents (head word is presented on fifoN_data).
    logic [DW-1:0] fq [5][$];
    int            pop_log [$];
    int            ew [5];

    // Reference model: mode 0 = init, 1 = idle, 2 = active.
    int            m_mode;
    int            m_ptr;
    int            m_credit;
    logic          m_push;
    logic [DW-1:0] m_dout;
    int            m_grant;

    logic [4:0]    obs_pop;
    logic          obs_idle;
    logic          obs_push;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int eff(input logic [3:0] w);
        return (w == 4'd0) ? 1 : int'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            emp[i] = (fq[i].size() == 0);
            din[i] = (fq[i].size() == 0) ? DW'($urandom) : fq[i][0];
        end
    endtask

    task automatic fill(input int i, input int n);
        logic [DW-1:0] w;
        repeat (n) begin
            w = DW'($urandom);
            fq[i].push_back(w);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 5; i++) fq[i].delete();
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_ptr    = 0;
        m_credit = 0;
        m_push   = 1'b0;
        m_dout   = '0;
        m_grant  = 0;
    endtask

    // One clock: predict and check at the falling edge, advance model at the
    // rising edge, then refresh FIFO-facing inputs 1 ns later.
    task automatic tick();
        int   p;
        int   k;
        int   nptr;
        int   ncr;
        int   nmode;
        logic anyne;
        @(negedge clk);
        p     = -1;
        nptr  = m_ptr;
        ncr   = m_credit;
        nmode = m_mode;
        anyne = (emp != 5'h1F);
        if (reset_L) begin
            if (m_mode == 0) begin
                nmode = 1;
                nptr  = 0;
                ncr   = ew[0];
            end else if (m_mode == 1) begin
                if (anyne) nmode = 2;
            end else begin
                if (!af) begin
                    if (!emp[m_ptr] && m_credit > 0) begin
                        p   = m_ptr;
                        ncr = m_credit - 1;
                    end else begin
                        for (int s = 1; s <= 5; s++) begin
                            k = (m_ptr + s) % 5;
                            if (p < 0 && !emp[k]) begin
                                p    = k;
                                nptr = k;
                                ncr  = ew[k] - 1;
                            end
                        end
                    end
                end
                if (p < 0 && !anyne) nmode = 1;
            end
        end
        obs_pop  = pop;
        obs_idle = idle;
        obs_push = push;
        chk("pop", 32'(pop), (p < 0) ? 32'd0 : (32'd1 << p));
        chk("push", 32'(push), 32'(m_push));
        chk("data_out", 32'(dout), 32'(m_dout));
        chk("grant_idx", 32'(gidx), 32'(m_grant));
        chk("IDLE", 32'(idle), 32'(m_mode == 1));
        if (p >= 0) pop_log.push_back(p);
        @(posedge clk);
        if (!reset_L) begin
            model_reset();
        end else begin
            m_push = (p >= 0);
            if (p >= 0) begin
                m_dout  = fq[p].pop_front();
                m_grant = p;
            end
            m_mode   = nmode;
            m_ptr    = nptr;
            m_credit = ncr;
        end
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic run_until_pops(input int n, input string tag);
        int guard;
        guard = 0;
        while (pop_log.size() < n && guard < 60) begin
            tick();
            guard++;
        end
        chk(tag, 32'(pop_log.size() >= n), 32'd1);
    endtask

    int wrr_tbl [11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 4};
    int sp_tbl  [3]  = '{2, 2, 4};
    int bp_tbl  [5]  = '{0, 0, 0, 0, 1};

    initial begin
        ew[0] = eff(TW0); ew[1] = eff(TW1); ew[2] = eff(TW2);
        ew[3] = eff(TW3); ew[4] = eff(TW4);
        reset_L = 1'b0;
        af      = 1'b0;
        model_reset();
        clear_all();
        for (int i = 0; i < 5; i++) fill(i, 30);
        drive();

        // Reset held with every FIFO non-empty, then INIT, one IDLE cycle, WRR.
        repeat (3) begin
            tick();
            chk("rst_pop", 32'(obs_pop), 32'd0);
            chk("rst_idle", 32'(obs_idle), 32'd0);
        end
        reset_L = 1'b1;
        tick();
        chk("init_idle", 32'(obs_idle), 32'd0);
        chk("init_pop", 32'(obs_pop), 32'd0);
        tick();
        chk("idle_once", 32'(obs_idle), 32'd1);
        chk("idle_pop", 32'(obs_pop), 32'd0);
        pop_log.delete();
        repeat (22) tick();
        chk("wrr_len", 32'(pop_log.size()), 32'd22);
        for (int i = 0; i < 22 && i < pop_log.size(); i++)
            chk("wrr_seq", 32'(pop_log[i]), 32'(wrr_tbl[i % 11]));

        // Back-pressure in the middle of FIFO0's turn with two credits left.
        do_reset();
        clear_all();
        for (int i = 0; i < 5; i++) fill(i, 10);
        drive();
        pop_log.delete();
        run_until_pops(2, "bp_reach");
        af = 1'b1;
        repeat (3) tick();
        chk("bp_nopop", 32'(pop_log.size()), 32'd2);
        af = 1'b0;
        run_until_pops(5, "bp_resume");
        for (int i = 0; i < 5 && i < pop_log.size(); i++)
            chk("bp_seq", 32'(pop_log[i]), 32'(bp_tbl[i]));

        // Sparse traffic: only FIFO2 and FIFO4, starting from ptr 0.
        do_reset();
        clear_all();
        fill(2, 6);
        fill(4, 3);
        drive();
        pop_log.delete();
        repeat (16) tick();
        chk("sparse_len", 32'(pop_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < pop_log.size(); i++)
            chk("sparse_seq", 32'(pop_log[i]), 32'(sp_tbl[i % 3]));
        chk("sparse_idle", 32'(obs_idle), 32'd1);

        // Drain to IDLE: FIFO1 with two words.
        do_reset();
        clear_all();
        fill(1, 2);
        drive();
        pop_log.delete();
        run_until_pops(2, "drain_reach");
        chk("drain_seq0", 32'(pop_log[0]), 32'd1);
        chk("drain_seq1", 32'(pop_log[1]), 32'd1);
        tick();
        chk("drain_last_push", 32'(obs_push), 32'd1);
        chk("drain_nopop", 32'(obs_pop), 32'd0);
        tick();
        chk("drain_idle", 32'(obs_idle), 32'd1);

        // Asynchronous reset while a push is in flight.
        do_reset();
        clear_all();
        for (int i = 0; i < 5; i++) fill(i, 10);
        drive();
        pop_log.delete();
        run_until_pops(3, "async_reach");
        chk("async_pre_push", 32'(push), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_push", 32'(push), 32'd0);
        chk("async_pop", 32'(pop), 32'd0);
        chk("async_idle", 32'(idle), 32'd0);
        model_reset();
        tick();
        tick();
        reset_L = 1'b1;

        // Randomised traffic and back-pressure against the model.
        for (int c = 0; c < 1500; c++) begin
            int rate;
            rate = ((c / 250) % 2 == 0) ? 30 : 6;
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 99) < rate && fq[i].size() < 8) fill(i, 1);
            af = ($urandom_range(0, 9) < 2);
            drive();
            tick();
        end

        // Let everything drain and confirm the arbiter parks in IDLE.
        af = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!(m_mode == 1 && emp == 5'h1F) && guard < 200) begin
                tick();
                guard++;
            end
        end
        tick();
        chk("final_idle", 32'(obs_idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
